// File: rtl/intr_ctrl.sv
// Interrupt sequencer: latches peripheral request edges, picks one by fixed priority,
// redirects fetch to the handler at a safe ID slot and restores the saved PC on eret.
module intr_ctrl #(
   parameter int          NSRC         = 4,
   parameter logic [31:0] HANDLER_ADDR = 32'h80000004
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   input  logic            id_valid,
   input  logic [31:0]     id_pc,
   input  logic            id_is_branch,
   input  logic            id_stall,
   input  logic            id_eret,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_addr,
   input  logic [31:0]     cfg_wdata,
   output logic [31:0]     cfg_rdata,
   output logic            exp_flush,
   output logic            redirect_valid,
   output logic [31:0]     redirect_pc,
   output logic            in_handler,
   output logic            irq_any
);

   localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_TAKE,
      S_HANDLER,
      S_RETURN
   } state_t;

   state_t state, state_next;

   logic [NSRC-1:0] mask, pending, irq_prev;
   logic [NSRC-1:0] masked, rise, w1c, take_clr;
   logic [CW-1:0]   cause, sel;
   logic [31:0]     epc;
   logic            eligible, slot_ok, take_now;

   logic            unused_wdata;

   assign unused_wdata = &{1'b0, cfg_wdata[31:NSRC]};

   assign masked   = pending & mask;
   assign eligible = |masked;
   assign irq_any  = eligible;
   assign slot_ok  = id_valid & ~id_is_branch & ~id_stall & ~id_pc[31];
   assign take_now = (state == S_ARM) && eligible && slot_ok;
   assign rise     = irq_src & ~irq_prev;
   assign w1c      = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NSRC-1:0] : '0;

   // Lowest set index wins; the selected bit is consumed on the ARM->TAKE edge
   always_comb begin
      sel = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (masked[i]) sel = CW'(i);
      end
      take_clr = take_now ? (NSRC'(1) << sel) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (eligible) state_next = S_ARM;
         S_ARM: begin
            if (!eligible)    state_next = S_IDLE;
            else if (slot_ok) state_next = S_TAKE;
         end
         S_TAKE:    state_next = S_HANDLER;
         S_HANDLER: if (id_valid && id_eret && !id_stall) state_next = S_RETURN;
         S_RETURN:  state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      exp_flush      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      in_handler     = 1'b0;
      case (state)
         S_TAKE: begin
            exp_flush      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = HANDLER_ADDR;
         end
         S_HANDLER: in_handler = 1'b1;
         S_RETURN: begin
            exp_flush      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = epc;
         end
         default: ;
      endcase
   end

   // New edges are OR'd in last so a set beats a same-cycle clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask     <= '0;
         pending  <= '0;
         irq_prev <= '0;
         cause    <= '0;
         epc      <= 32'd0;
      end else begin
         irq_prev <= irq_src;
         pending  <= (pending & ~w1c & ~take_clr) | rise;
         if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata[NSRC-1:0];
         if (take_now) begin
            cause <= sel;
            epc   <= id_pc;
         end
      end
   end

   always_comb begin
      case (cfg_addr)
         2'd0:    cfg_rdata = {{(32-NSRC){1'b0}}, mask};
         2'd1:    cfg_rdata = {{(32-NSRC){1'b0}}, pending};
         2'd2:    cfg_rdata = {{(32-CW){1'b0}}, cause};
         default: cfg_rdata = epc;
      endcase
   end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Interrupt sequencer for the 5-stage pipeline. Latches peripheral interrupt requests (SysTick, UART, external) and picks one by fixed priority. When the instruction in ID can be interrupted, it flushes the front end, saves the return PC and redirects fetch to the handler. On return-from-exception it restores fetch to the saved PC. Sits beside ID and drives the ExpFlush/PC-redirect path into IF; its config registers are memory-mapped in MEM.

Parameters:
NSRC, 4, number of interrupt sources; index 0 is highest priority
HANDLER_ADDR, 32'h80000004, handler entry PC; kernel mode when PC[31]=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
irq_src  in  NSRC  level request lines, rising edge = new request
id_valid  in  1  ID holds a real (non-bubble) instruction
id_pc  in  32  PC of the instruction in ID
id_is_branch  in  1  ID instruction is branch/jump (delay-slot hazard)
id_stall  in  1  load-use stall active this cycle
id_eret  in  1  ID decodes the return instruction (jr $26)
cfg_we  in  1  MEM-stage write strobe to controller registers
cfg_addr  in  2  0=MASK, 1=PENDING, 2=CAUSE, 3=EPC
cfg_wdata  in  32  write data
cfg_rdata  out  32  read data, combinational on cfg_addr
exp_flush  out  1  one-cycle pulse: flush IF/ID, kill ID instruction
redirect_valid  out  1  one-cycle pulse: IF loads redirect_pc
redirect_pc  out  32  handler address or EPC
in_handler  out  1  handler executing; further interrupts blocked
irq_any  out  1  OR of (pending & mask), for the Irq status bit

Behaviour:
- Reset (reset=0, async): state IDLE; mask=0, pending=0, cause=0, epc=0, edge history=0. All outputs 0; redirect_pc=0.
- Edge detect: irq_prev is a registered copy of irq_src. pending[i] is set the cycle after irq_src[i] goes 0->1.
- MASK write: mask <= cfg_wdata[NSRC-1:0].
- PENDING write is write-1-to-clear. If the same bit sees a set and a clear in one cycle, the set wins.
- CAUSE/EPC are read-only. Writes to them are ignored. Unused rdata bits read 0.
- eligible = |(pending & mask).
- slot_ok = id_valid & !id_is_branch & !id_stall & !id_pc[31].
- FSM states:
  - IDLE: if eligible -> ARM.
  - ARM: if !eligible -> IDLE (request withdrawn or masked). Else if slot_ok -> TAKE. Else stay in ARM.
  - TAKE (exactly 1 cycle):
    - exp_flush=1, redirect_valid=1, redirect_pc=HANDLER_ADDR.
    - epc <= id_pc; the interrupted instruction re-executes on return.
    - cause <= index of the lowest set bit of pending & mask, evaluated in the ARM cycle that moved to TAKE.
    - That pending bit is cleared. Goes to HANDLER.
  - HANDLER: in_handler=1. New edges still set pending bits but are not taken. If id_valid & id_eret & !id_stall -> RETURN.
  - RETURN (exactly 1 cycle): redirect_valid=1, redirect_pc=epc, exp_flush=1 (kills the instruction after eret). Goes to IDLE; an eligible request re-enters ARM on the next cycle.
- id_eret outside HANDLER is ignored (no redirect).
- Latency: irq edge at cycle n -> pending at n+1 -> ARM at n+2 -> earliest TAKE at n+3.
- A branch or stall in ID delays TAKE cycle by cycle with no limit. No request is lost while waiting.
- Reset asserted mid-TAKE/RETURN aborts immediately; no partial epc/cause update survives.
- irq_any = eligible, registered-free (combinational from registers).

Test Plan:
- Reset: hold reset=0 with irq_src=4'hF -> all outputs 0, cfg_rdata=0 at every addr. Release -> pending=4'hF one cycle later, no TAKE since mask=0.
- Basic take/return: mask=4'h1, pulse irq_src[0], id_pc=32'h00000040, slot_ok=1 -> TAKE at n+3: exp_flush=1, redirect_pc=32'h80000004, epc=32'h40, cause=0. Then id_eret -> RETURN redirect_pc=32'h40, in_handler drops.
- Priority: mask=4'hF, edges on src2 and src1 same cycle -> cause=1, pending=4'h4 after TAKE. After RETURN the controller re-arms and takes src2 (cause=2).
- Slot blocking: ARM with id_is_branch=1 for 3 cycles, then id_stall=1 for 1 cycle -> TAKE on the first clean cycle only; epc equals that cycle's id_pc.
- Withdraw/W1C: in ARM, write PENDING=4'h1 (clear) on the only pending bit -> back to IDLE, no flush. Write-1-clear in the same cycle as a new edge on that bit -> bit stays 1.
- Nested block: src3 edge during HANDLER -> pending[3]=1, irq_any=1, no TAKE until after RETURN. A spurious id_eret in IDLE produces no redirect.
